// File: rtl/tftp_decode.sv
// Receive-side TFTP header decoder for a read-only TFTP server.
// Captures the Ethernet/IP/UDP/TFTP header fields byte by byte, decides at
// byte index 45 whether the frame is an acceptable RRQ or ACK, and publishes
// the client TID, the next DATA block number and the DATA payload length.
module tftp_decode #(
    parameter logic [15:0] TFTP_PORT  = 16'd69,
    parameter logic [15:0] SERVER_TID = 16'h0400,
    parameter logic [9:0]  BLOCK_SIZE = 10'd512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  cnt,
    input  logic [7:0]  eth_data,
    input  logic [15:0] udp_dst,
    output logic        valid,
    output logic [15:0] tid,
    output logic [15:0] next_block_no,
    output logic [9:0]  length
);

    // Header capture registers
    logic [15:0] ethertype_q, ethertype_d;
    logic [7:0]  proto_q, proto_d;
    logic [15:0] src_port_q, src_port_d;
    logic [15:0] opcode_q, opcode_d;
    logic [7:0]  blk_hi_q, blk_hi_d;

    // Published outputs
    logic        valid_q, valid_d;
    logic [15:0] tid_q, tid_d;
    logic [15:0] next_block_q, next_block_d;
    logic [9:0]  length_q, length_d;

    // Decision terms
    logic [15:0] rx_block_s;
    logic        ip_udp_s;
    logic        is_rrq_s;
    logic        is_ack_s;
    logic        accept_s;
    logic [15:0] next_blk_s;

    // Acceptance test; the block number low byte comes straight off the bus
    always_comb begin
        rx_block_s = {blk_hi_q, eth_data};
        ip_udp_s   = (ethertype_q == 16'h0800) && (proto_q == 8'd17);
        is_rrq_s   = (opcode_q == 16'd1) && (udp_dst == TFTP_PORT);
        is_ack_s   = (opcode_q == 16'd4) && (udp_dst == SERVER_TID);
        accept_s   = ip_udp_s && (is_rrq_s || is_ack_s);
        if (is_rrq_s) begin
            next_blk_s = 16'd1;
        end else begin
            next_blk_s = rx_block_s + 16'd1;
        end
    end

    // Next-state for capture and output registers, keyed on the byte index
    always_comb begin
        ethertype_d  = ethertype_q;
        proto_d      = proto_q;
        src_port_d   = src_port_q;
        opcode_d     = opcode_q;
        blk_hi_d     = blk_hi_q;
        valid_d      = valid_q;
        tid_d        = tid_q;
        next_block_d = next_block_q;
        length_d     = length_q;
        case (cnt)
            8'd0:  valid_d = 1'b0;
            8'd12: ethertype_d[15:8] = eth_data;
            8'd13: ethertype_d[7:0]  = eth_data;
            8'd23: proto_d           = eth_data;
            8'd34: src_port_d[15:8]  = eth_data;
            8'd35: src_port_d[7:0]   = eth_data;
            8'd42: opcode_d[15:8]    = eth_data;
            8'd43: opcode_d[7:0]     = eth_data;
            8'd44: blk_hi_d          = eth_data;
            8'd45: begin
                if (accept_s) begin
                    valid_d      = 1'b1;
                    tid_d        = src_port_q;
                    next_block_d = next_blk_s;
                    length_d     = BLOCK_SIZE;
                end else begin
                    valid_d      = valid_q;
                end
            end
            default: valid_d = valid_q;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            ethertype_q  <= 16'd0;
            proto_q      <= 8'd0;
            src_port_q   <= 16'd0;
            opcode_q     <= 16'd0;
            blk_hi_q     <= 8'd0;
            valid_q      <= 1'b0;
            tid_q        <= 16'd0;
            next_block_q <= 16'd0;
            length_q     <= 10'd0;
        end else begin
            ethertype_q  <= ethertype_d;
            proto_q      <= proto_d;
            src_port_q   <= src_port_d;
            opcode_q     <= opcode_d;
            blk_hi_q     <= blk_hi_d;
            valid_q      <= valid_d;
            tid_q        <= tid_d;
            next_block_q <= next_block_d;
            length_q     <= length_d;
        end
    end

    assign valid         = valid_q;
    assign tid           = tid_q;
    assign next_block_no = next_block_q;
    assign length        = length_q;

endmodule

// File: tb/tb_tftp_decode.sv
// Self-checking bench for tftp_decode: directed and randomized frames checked
// every clock against a frame-level reference model.
module tb_tftp_decode;

    logic        clk;
    logic        reset;
    logic [7:0]  cnt;
    logic [7:0]  eth_data;
    logic [15:0] udp_dst;
    logic        valid;
    logic [15:0] tid;
    logic [15:0] next_block_no;
    logic [9:0]  length;

    tftp_decode dut (
        .clk           (clk),
        .reset         (reset),
        .cnt           (cnt),
        .eth_data      (eth_data),
        .udp_dst       (udp_dst),
        .valid         (valid),
        .tid           (tid),
        .next_block_no (next_block_no),
        .length        (length)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [7:0] frame [0:127];

    // Reference model outputs
    logic        exp_valid;
    logic [15:0] exp_tid;
    logic [15:0] exp_nb;
    logic [9:0]  exp_len;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".valid"},  {31'd0, valid},        {31'd0, exp_valid});
        chk({tag, ".tid"},    {16'd0, tid},          {16'd0, exp_tid});
        chk({tag, ".nb"},     {16'd0, next_block_no}, {16'd0, exp_nb});
        chk({tag, ".length"}, {22'd0, length},       {22'd0, exp_len});
    endtask

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_tid   = 16'd0;
        exp_nb    = 16'd0;
        exp_len   = 10'd0;
    endtask

    // Whole-frame rule: decide acceptance from the header fields
    task automatic model_decide(input logic [15:0] dst);
        logic [15:0] etype, op, blk, src;
        etype = {frame[12], frame[13]};
        op    = {frame[42], frame[43]};
        blk   = {frame[44], frame[45]};
        src   = {frame[34], frame[35]};
        if (etype == 16'h0800 && frame[23] == 8'd17 &&
            ((op == 16'd1 && dst == 16'd69) || (op == 16'd4 && dst == 16'h0400))) begin
            exp_valid = 1'b1;
            exp_tid   = src;
            exp_nb    = (op == 16'd1) ? 16'd1 : 16'((int'(blk) + 1) % 65536);
            exp_len   = 10'd512;
        end
    endtask

    task automatic build_frame(input logic [15:0] etype, input logic [7:0] proto,
                               input logic [15:0] src, input logic [15:0] op,
                               input logic [15:0] blk);
        for (int i = 0; i < 128; i++) frame[i] = 8'($urandom_range(0, 255));
        frame[12] = etype[15:8]; frame[13] = etype[7:0];
        frame[23] = proto;
        frame[34] = src[15:8];   frame[35] = src[7:0];
        frame[42] = op[15:8];    frame[43] = op[7:0];
        frame[44] = blk[15:8];   frame[45] = blk[7:0];
    endtask

    // Present a frame one byte per clock; rst_at>=0 pulls reset at that index and aborts
    task automatic send_frame(input string tag, input int len, input logic [15:0] dst,
                              input int rst_at);
        for (int k = 0; k < len; k++) begin
            cnt      = 8'(k);
            eth_data = frame[k];
            udp_dst  = dst;
            reset    = (k == rst_at) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (k == rst_at) begin
                model_reset();
                chk_outputs({tag, ".rst"});
                reset = 1'b1;
                return;
            end
            if (k == 0) exp_valid = 1'b0;
            if (k == 45) model_decide(dst);
            chk_outputs(tag);
        end
    endtask

    task automatic idle(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            cnt      = 8'hFF;
            eth_data = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
            chk_outputs(tag);
        end
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cnt      = 8'($urandom_range(0, 255));
            eth_data = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
            model_reset();
            chk_outputs(tag);
        end
        reset = 1'b1;
    endtask

    initial begin
        logic [15:0] rdst;
        logic [15:0] rop;
        int          rlen;
        reset    = 1'b0;
        cnt      = 8'hFF;
        eth_data = 8'd0;
        udp_dst  = 16'd0;
        model_reset();

        do_reset("reset");

        // RRQ, three times with reset between
        for (int r = 0; r < 3; r++) begin
            build_frame(16'h0800, 8'd17, 16'h0400, 16'd1, 16'h1234);
            send_frame("rrq", 71, 16'h0045, -1);
            chk("rrq.valid_const", {31'd0, valid}, 32'd1);
            chk("rrq.tid_const", {16'd0, tid}, 32'h0400);
            chk("rrq.nb_const", {16'd0, next_block_no}, 32'd1);
            chk("rrq.len_const", {22'd0, length}, 32'h200);
            idle("rrq.idle", 3);
            do_reset("rrq.reset");
        end

        // ACK block 1, three times with reset between
        for (int r = 0; r < 3; r++) begin
            build_frame(16'h0800, 8'd17, 16'h0400, 16'd4, 16'h0001);
            send_frame("ack", 60, 16'h0400, -1);
            chk("ack.nb_const", {16'd0, next_block_no}, 32'd2);
            chk("ack.valid_const", {31'd0, valid}, 32'd1);
            idle("ack.idle", 2);
            do_reset("ack.reset");
        end

        // ACK wraparound
        build_frame(16'h0800, 8'd17, 16'h0400, 16'd4, 16'hFFFF);
        send_frame("wrap", 60, 16'h0400, -1);
        chk("wrap.nb_const", {16'd0, next_block_no}, 32'd0);
        chk("wrap.valid_const", {31'd0, valid}, 32'd1);

        // Accept with a distinct TID, then rejects must leave outputs unchanged
        build_frame(16'h0800, 8'd17, 16'hBEEF, 16'd4, 16'h0041);
        send_frame("pre", 60, 16'h0400, -1);
        build_frame(16'h0800, 8'd17, 16'h1111, 16'd1, 16'h0000);
        send_frame("rej.rrq_port", 60, 16'h0400, -1);
        build_frame(16'h0800, 8'd17, 16'h2222, 16'd4, 16'h0007);
        send_frame("rej.ack_port", 60, 16'h0045, -1);
        build_frame(16'h0800, 8'd17, 16'h3333, 16'd2, 16'h0000);
        send_frame("rej.wrq", 60, 16'h0045, -1);
        build_frame(16'h86DD, 8'd17, 16'h4444, 16'd1, 16'h0000);
        send_frame("rej.ipv6", 60, 16'h0045, -1);
        chk("rej.tid_const", {16'd0, tid}, 32'hBEEF);
        chk("rej.nb_const", {16'd0, next_block_no}, 32'h0042);
        chk("rej.valid_const", {31'd0, valid}, 32'd0);

        // Reset at cnt 44 of a valid RRQ, then a clean frame
        build_frame(16'h0800, 8'd17, 16'h0555, 16'd1, 16'h0000);
        send_frame("midrst", 71, 16'h0045, 44);
        build_frame(16'h0800, 8'd17, 16'h0666, 16'd1, 16'h0000);
        send_frame("after_rst", 71, 16'h0045, -1);

        // Back-to-back: accepted ACK then rejected frame, no idle
        build_frame(16'h0800, 8'd17, 16'h0777, 16'd4, 16'h00A0);
        send_frame("b2b.ack", 60, 16'h0400, -1);
        build_frame(16'h0800, 8'd6, 16'h0888, 16'd4, 16'h00B0);
        send_frame("b2b.rej", 60, 16'h0400, -1);
        chk("b2b.tid_const", {16'd0, tid}, 32'h0777);
        chk("b2b.nb_const", {16'd0, next_block_no}, 32'h00A1);

        // Short frame never reaches the decision edge
        build_frame(16'h0800, 8'd17, 16'h0999, 16'd1, 16'h0000);
        send_frame("short", 40, 16'h0045, -1);

        // Randomized frames
        for (int r = 0; r < 40; r++) begin
            rop = 16'($urandom_range(0, 6));
            case ($urandom_range(0, 2))
                0:       rdst = 16'd69;
                1:       rdst = 16'h0400;
                default: rdst = 16'($urandom_range(0, 65535));
            endcase
            rlen = ($urandom_range(0, 4) == 0) ? 30 : int'($urandom_range(46, 100));
            build_frame(($urandom_range(0, 3) == 0) ? 16'h86DD : 16'h0800,
                        ($urandom_range(0, 3) == 0) ? 8'd6 : 8'd17,
                        16'($urandom_range(0, 65535)), rop,
                        16'($urandom_range(0, 65535)));
            send_frame("rand", rlen, rdst, -1);
            if ($urandom_range(0, 1) == 1) idle("rand.idle", 2);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
